// File: rtl/systolic_pkg.sv
// systolic_pkg: shared control encodings and FSM states for the systolic array sequencer.
package systolic_pkg;

    localparam logic [1:0] IB_HOLD = 2'b00;
    localparam logic [1:0] IB_WR   = 2'b01;
    localparam logic [1:0] IB_RD   = 2'b10;
    localparam logic [1:0] IB_CLR  = 2'b11;

    localparam logic [1:0] PE_HOLD = 2'b00;
    localparam logic [1:0] PE_CLR  = 2'b01;
    localparam logic [1:0] PE_MAC  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_IN,
        S_CLEAR,
        S_COMPUTE,
        S_DONE
    } state_t;

endpackage

// File: rtl/systolic_ctrl_skew_window.sv
// skew_window: flags when the compute step counter lies inside [lo, hi].
module skew_window #(
    parameter int bits = 4
) (
    input  logic [bits-1:0] t,
    input  logic [bits-1:0] lo,
    input  logic [bits-1:0] hi,
    output logic            hit
);

    assign hit = (t >= lo) && (t <= hi);

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: loads weight/input buffers from one source, clears the PEs and
// issues skewed read/MAC enables so every PE accumulates one dot product.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int width  = 16,
    parameter int rows   = 4,
    parameter int cols   = 4,
    parameter int vector = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   src_valid,
    input  logic [width-1:0]       src_data,
    output logic                   src_ready,
    output logic                   busy,
    output logic                   done,
    output logic [rows*cols*2-1:0] ctlpe,
    output logic [rows*2-1:0]      ctlbw,
    output logic [cols*2-1:0]      ctlbin,
    output logic [width-1:0]       w,
    output logic [width-1:0]       in
);

    localparam int T  = rows + cols + vector - 1;
    localparam int KW = $clog2(((rows > cols) ? rows : cols) * vector + 1);
    localparam int TW = $clog2(T + 1);
    localparam logic [KW-1:0] K_W_LAST  = KW'(rows * vector - 1);
    localparam logic [KW-1:0] K_IN_LAST = KW'(cols * vector - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(T - 1);

    state_t                   state, state_n;
    logic [KW-1:0]            k, k_n;
    logic [TW-1:0]            t, t_n;
    logic [rows-1:0]          win_w;
    logic [cols-1:0]          win_in;
    logic [rows*cols-1:0]     win_pe;
    logic [rows*cols*2-1:0]   ctlpe_n;
    logic [rows*2-1:0]        ctlbw_n;
    logic [cols*2-1:0]        ctlbin_n;
    logic [width-1:0]         w_n, in_n;
    logic                     hs;

    assign src_ready = (state == S_LOAD_W) || (state == S_LOAD_IN);
    assign busy      = state != S_IDLE;
    assign hs        = src_valid && src_ready;

    // Diagonal wavefront: row r / column c start reading r / c steps late, PE(r,c) one step after both arrive
    for (genvar r = 0; r < rows; r++) begin : g_w
        skew_window #(.bits(TW)) u_win (
            .t  (t),
            .lo (TW'(r)),
            .hi (TW'(r + vector - 1)),
            .hit(win_w[r])
        );
    end

    for (genvar c = 0; c < cols; c++) begin : g_in
        skew_window #(.bits(TW)) u_win (
            .t  (t),
            .lo (TW'(c)),
            .hi (TW'(c + vector - 1)),
            .hit(win_in[c])
        );
    end

    for (genvar r = 0; r < rows; r++) begin : g_pr
        for (genvar c = 0; c < cols; c++) begin : g_pc
            skew_window #(.bits(TW)) u_win (
                .t  (t),
                .lo (TW'(r + c + 1)),
                .hi (TW'(r + c + vector)),
                .hit(win_pe[r*cols+c])
            );
        end
    end

    always_comb begin
        state_n  = state;
        k_n      = k;
        t_n      = t;
        ctlpe_n  = '0;
        ctlbw_n  = '0;
        ctlbin_n = '0;
        w_n      = w;
        in_n     = in;
        case (state)
            S_IDLE: begin
                state_n = start ? S_LOAD_W : S_IDLE;
                k_n     = '0;
            end
            S_LOAD_W: if (hs) begin
                w_n = src_data;
                for (int r = 0; r < rows; r++)
                    if (int'(k) / vector == r) ctlbw_n[2*r +: 2] = IB_WR;
                k_n     = (k == K_W_LAST) ? '0 : k + 1'b1;
                state_n = (k == K_W_LAST) ? S_LOAD_IN : S_LOAD_W;
            end
            S_LOAD_IN: if (hs) begin
                in_n = src_data;
                for (int c = 0; c < cols; c++)
                    if (int'(k) / vector == c) ctlbin_n[2*c +: 2] = IB_WR;
                k_n     = (k == K_IN_LAST) ? '0 : k + 1'b1;
                state_n = (k == K_IN_LAST) ? S_CLEAR : S_LOAD_IN;
            end
            S_CLEAR: begin
                ctlpe_n = {rows*cols{PE_CLR}};
                t_n     = '0;
                state_n = S_COMPUTE;
            end
            S_COMPUTE: begin
                for (int r = 0; r < rows; r++)
                    ctlbw_n[2*r +: 2] = win_w[r] ? IB_RD : IB_HOLD;
                for (int c = 0; c < cols; c++)
                    ctlbin_n[2*c +: 2] = win_in[c] ? IB_RD : IB_HOLD;
                for (int p = 0; p < rows*cols; p++)
                    ctlpe_n[2*p +: 2] = win_pe[p] ? PE_MAC : PE_HOLD;
                t_n     = t + 1'b1;
                state_n = (t == T_LAST) ? S_DONE : S_COMPUTE;
            end
            S_DONE: begin
                t_n     = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            k      <= '0;
            t      <= '0;
            ctlpe  <= '0;
            ctlbw  <= '0;
            ctlbin <= '0;
            w      <= '0;
            in     <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            t      <= t_n;
            ctlpe  <= ctlpe_n;
            ctlbw  <= ctlbw_n;
            ctlbin <= ctlbin_n;
            w      <= w_n;
            in     <= in_n;
            done   <= state == S_DONE;
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed checks of the sequencer, with a buffer/PE observer
// that rebuilds IB contents and MAC windows from the control outputs.
module tb_systolic_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, src_valid;
    logic [15:0] src_data;
    logic        src_ready, busy, done;
    logic [31:0] ctlpe;
    logic [7:0]  ctlbw, ctlbin;
    logic [15:0] w, in;

    logic        start_s, valid_s;
    logic [15:0] data_s;
    logic        ready_s, busy_s, done_s;
    logic [11:0] ctlpe_s;
    logic [3:0]  ctlbw_s;
    logic [5:0]  ctlbin_s;
    logic [15:0] w_s, in_s;

    int passed = 0, fails = 0, total = 0;

    always #5 clk = ~clk;

    systolic_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .busy(busy), .done(done), .ctlpe(ctlpe), .ctlbw(ctlbw),
        .ctlbin(ctlbin), .w(w), .in(in)
    );

    systolic_ctrl #(.width(16), .rows(2), .cols(3), .vector(5)) u_sw (
        .clk(clk), .rst(rst), .start(start_s), .src_valid(valid_s), .src_data(data_s),
        .src_ready(ready_s), .busy(busy_s), .done(done_s), .ctlpe(ctlpe_s), .ctlbw(ctlbw_s),
        .ctlbin(ctlbin_s), .w(w_s), .in(in_s)
    );

    // Observer for the default instance; statistics restart when busy rises (cycle 1 after start)
    int          cyc, done_cyc, done_cnt, clear_cyc, bad11;
    int          wcnt[4], icnt[4], rdin_cnt[4], rdin_first[4], rdin_last[4];
    int          mac_cnt[16], mac_first[16], mac_last[16];
    logic [15:0] wib[4][4], inib[4][4];
    logic        busy_d = 1'b0;

    always @(negedge clk) begin
        int tt;
        if (busy === 1'b1 && busy_d !== 1'b1) begin
            cyc = 1; done_cyc = 0; done_cnt = 0; clear_cyc = 0; bad11 = 0;
            for (int i = 0; i < 4; i++) begin
                wcnt[i] = 0; icnt[i] = 0; rdin_cnt[i] = 0; rdin_first[i] = -1; rdin_last[i] = -1;
            end
            for (int i = 0; i < 16; i++) begin
                mac_cnt[i] = 0; mac_first[i] = -1; mac_last[i] = -1;
            end
        end else cyc++;
        busy_d = busy;
        for (int r = 0; r < 4; r++) begin
            if (ctlbw[2*r +: 2] == 2'b01) begin
                if (wcnt[r] < 4) wib[r][wcnt[r]] = w;
                wcnt[r]++;
            end
            if (ctlbin[2*r +: 2] == 2'b01) begin
                if (icnt[r] < 4) inib[r][icnt[r]] = in;
                icnt[r]++;
            end
            if (ctlbin[2*r +: 2] == 2'b10) begin
                tt = cyc - clear_cyc - 1;
                if (rdin_cnt[r] == 0) rdin_first[r] = tt;
                rdin_last[r] = tt;
                rdin_cnt[r]++;
            end
        end
        if (ctlpe[1:0] == 2'b01) clear_cyc = cyc;
        for (int p = 0; p < 16; p++) begin
            if (ctlpe[2*p +: 2] == 2'b10) begin
                tt = cyc - clear_cyc - 1;
                if (mac_cnt[p] == 0) mac_first[p] = tt;
                mac_last[p] = tt;
                mac_cnt[p]++;
            end
            if (ctlpe[2*p +: 2] == 2'b11) bad11++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Observer for the 2x3x5 instance
    int   cyc2, done_cnt2, done_cyc2, clear_cyc2, bad2, mac5_cnt, mac5_last;
    logic busy_s_d = 1'b0;

    always @(negedge clk) begin
        if (busy_s === 1'b1 && busy_s_d !== 1'b1) begin
            cyc2 = 1; done_cnt2 = 0; done_cyc2 = 0; clear_cyc2 = 0; bad2 = 0; mac5_cnt = 0; mac5_last = -1;
        end else cyc2++;
        busy_s_d = busy_s;
        if (ctlpe_s[1:0] == 2'b01) clear_cyc2 = cyc2;
        for (int p = 0; p < 6; p++)
            if (ctlpe_s[2*p +: 2] == 2'b11) bad2++;
        if (ctlpe_s[11:10] == 2'b10) begin
            mac5_cnt++;
            mac5_last = cyc2 - clear_cyc2 - 1;
        end
        if (done_s === 1'b1) begin
            done_cnt2++;
            done_cyc2 = cyc2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dot(input int r, input int c);
        int s = 0;
        for (int j = 0; j < 4; j++) s += int'(wib[r][j]) * int'(inib[c][j]);
        return s;
    endfunction

    // Presents words base, base+1, ... ; with stall, valid only on even cycles of the job
    task automatic feed(input int n, input int base, input bit stall);
        int got = 0;
        int j = 1;
        while (got < n && j < 400) begin
            src_valid = !stall || (j % 2 == 0);
            src_data  = 16'(base + got);
            if (src_valid && src_ready) got++;
            @(negedge clk); #1;
            j++;
        end
        src_valid = 1'b0;
        check("feed_words", got, n);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0;
        start_s = 1'b0; valid_s = 1'b0; data_s = 16'd3;
        repeat (2) @(negedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_ready", src_ready, 0);
        check("rst_done", done, 0);
        check("rst_ctlpe", ctlpe, 0);
        check("rst_ctlbw", ctlbw, 0);
        check("rst_ctlbin", ctlbin, 0);
        check("rst_w", w, 0);
        check("rst_in", in, 0);
        rst = 1'b1;
        @(negedge clk); #1;

        // Back-to-back job: weights 1..16, inputs 17..32
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        feed(32, 1, 1'b0);
        check("ready_low_compute", src_ready, 0);
        wait_done();
        check("done_cycle", done_cyc, 46);
        check("done_count", done_cnt, 1);
        check("load_len", clear_cyc - 2, 32);
        check("ib0_words", wcnt[0], 4);
        check("ib1_words", wcnt[1], 4);
        check("ib1_first", wib[1][0], 5);
        check("ib1_last", wib[1][3], 8);
        check("pe00_result", dot(0, 0), 190);
        check("pe33_result", dot(3, 3), 1774);
        check("pe00_first", mac_first[0], 1);
        check("pe00_last", mac_last[0], 4);
        check("pe33_first", mac_first[15], 7);
        check("pe33_last", mac_last[15], 10);
        check("pe33_count", mac_cnt[15], 4);
        check("bin2_first", rdin_first[2], 2);
        check("bin2_last", rdin_last[2], 5);
        check("bin2_count", rdin_cnt[2], 4);
        check("no_pe_11", bad11, 0);
        check("w_hold", w, 16);
        check("in_hold", in, 32);

        // start held high for a whole job: next job begins right after done
        start = 1'b1;
        @(negedge clk); #1;
        feed(32, 1, 1'b0);
        wait_done();
        check("held_done_count", done_cnt, 1);
        check("held_idle_at_done", busy, 0);
        @(negedge clk); #1;
        start = 1'b0;
        check("held_restart", busy, 1);

        // Abort the restarted job after five weights (k=5)
        feed(5, 1, 1'b0);
        check("pre_rst_ctlbw", ctlbw, 8'h04);
        check("pre_rst_w", w, 5);
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", src_ready, 0);
        check("arst_ctlbw", ctlbw, 0);
        check("arst_w", w, 0);
        check("arst_done", done, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk); #1;
        check("no_partial_done", done_cnt, 0);
        check("abort_idle", busy, 0);

        // Stalling source: valid every other cycle
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        feed(32, 1, 1'b1);
        wait_done();
        check("stall_load_len", clear_cyc - 2, 64);
        check("stall_done_cycle", done_cyc, 78);
        check("stall_pe00", dot(0, 0), 190);
        check("stall_pe33", dot(3, 3), 1774);
        check("stall_pe33_count", mac_cnt[15], 4);

        // 2x3 array, vector 5
        start_s = 1'b1; valid_s = 1'b1;
        @(negedge clk); #1;
        start_s = 1'b0;
        for (int n = 0; n < 200 && done_s !== 1'b1; n++) begin
            @(negedge clk); #1;
        end
        check("sw_done_seen", done_s, 1);
        repeat (5) @(negedge clk); #1;
        valid_s = 1'b0;
        check("sw_T", done_cyc2 - clear_cyc2 - 1, 9);
        check("sw_done_cycle", done_cyc2, 37);
        check("sw_done_count", done_cnt2, 1);
        check("sw_no_pe_11", bad2, 0);
        check("sw_pe12_count", mac5_cnt, 5);
        check("sw_pe12_last", mac5_last, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
